// File: rtl/uart_ctrl_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_ctrl_pkg;

    localparam int unsigned ByteW           = 8;
    localparam int unsigned DefNumReq       = 4;
    localparam int unsigned DefStartTimeout = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitBusy = 2'd1,
        StWaitDone = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set request at or above rr_ptr, wrapping around.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    rr_ptr,
    output logic               valid,
    output logic [IdxW-1:0]    idx
);

    int unsigned j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(rr_ptr) + k) % NUM_REQ;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that issues one byte at a time into the UART TX write latch
// and waits for the frame to complete before issuing the next.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DefNumReq,
    parameter int unsigned START_TIMEOUT = DefStartTimeout,
    parameter int unsigned IdxW          = $clog2(NUM_REQ)
) (
    input  logic                     clk_50M,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [ByteW*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     write,
    output logic [ByteW-1:0]         write_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [IdxW-1:0]          grant_id,
    output logic                     busy,
    output logic                     start_err,
    input  logic                     err_clr
);

    localparam int unsigned TmrW = $clog2(START_TIMEOUT) + 1;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ByteW-1:0]    hold_q, hold_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                write_q, write_d;
    logic [TmrW-1:0]     timer_q, timer_d;
    logic                err_q, err_d;
    logic                set_err;

    logic                pick_valid;
    logic [IdxW-1:0]     pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        grant_d  = grant_q;
        ack_d    = '0;
        write_d  = 1'b0;
        timer_d  = timer_q;
        set_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    ack_d[pick_idx] = 1'b1;
                    write_d         = 1'b1;
                    hold_d          = req_data[ByteW*32'(pick_idx) +: ByteW];
                    grant_d         = pick_idx;
                    rr_ptr_d        = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    timer_d         = '0;
                    state_d         = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // A transmitter fast enough to finish before we see busy still counts as done.
                if (tx_done) begin
                    state_d = StIdle;
                end else if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TmrW'(START_TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (set_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            write_q  <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            write_q  <= write_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    assign ack        = ack_q;
    assign write      = write_q;
    assign write_data = hold_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != StIdle);
    assign start_err  = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed vector table, timeout/fairness sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int ST = 16;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        write;
    logic [7:0]  write_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        start_err;
    logic        err_clr;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_scheduler #(
        .NUM_REQ       (N),
        .START_TIMEOUT (ST)
    ) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .write      (write),
        .write_data (write_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .start_err  (start_err),
        .err_clr    (err_clr)
    );

    always #10 clk_50M = ~clk_50M;

    // Reference model: one outstanding byte, its age, and whether the transmitter started.
    bit         m_inflight, m_started, m_write, m_err;
    int         m_age, m_ptr;
    logic [3:0] m_ack;
    logic [7:0] m_data;
    logic [1:0] m_grant;

    task automatic model_edge();
        bit found;
        bit set_err;
        int w;
        found   = 1'b0;
        set_err = 1'b0;
        w       = 0;
        if (reset) begin
            m_inflight = 0; m_started = 0; m_write = 0; m_err = 0;
            m_age = 0; m_ptr = 0; m_ack = '0; m_data = '0; m_grant = '0;
            return;
        end
        m_ack   = '0;
        m_write = 1'b0;
        if (!m_inflight) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_ack      = 4'(1 << w);
                m_write    = 1'b1;
                m_data     = req_data[8*w +: 8];
                m_grant    = 2'(w);
                m_ptr      = (w + 1) % N;
                m_inflight = 1'b1;
                m_started  = 1'b0;
                m_age      = 0;
            end
        end else if (!m_started) begin
            if (tx_done) m_inflight = 1'b0;
            else if (tx_busy) m_started = 1'b1;
            else if (m_age == ST - 1) begin
                set_err    = 1'b1;
                m_inflight = 1'b0;
            end
            m_age++;
        end else if (tx_done) begin
            m_inflight = 1'b0;
        end
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    function automatic logic [16:0] dut_vec();
        return {ack, write, write_data, grant_id, busy, start_err};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk_50M);
        #1;
    endtask

    // Directed vector table: inputs before an edge, outputs expected after it.
    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [31:0] rd;
        logic        bz, dn, clr;
        logic [3:0]  e_ack;
        logic        e_wr;
        logic [7:0]  e_wd;
        logic [1:0]  e_gid;
        logic        e_bsy, e_err;
    } vec_t;

    vec_t vecs[14];

    // Transmitter and requester stimulus for the model-checked phases.
    bit tx_on, tx_fast;
    int tx_age, tx_d, tx_l;

    task automatic drive(input bit fair);
        int p;
        if (m_write) begin
            tx_age  = 0;
            tx_fast = 1'b0;
            tx_on   = 1'b1;
            if (fair) begin
                tx_d = 2; tx_l = 20;
            end else begin
                p = $urandom_range(0, 3);
                if (p == 0) tx_on = 1'b0;
                else if (p == 1) tx_fast = 1'b1;
                else begin
                    tx_d = $urandom_range(0, 4);
                    tx_l = $urandom_range(1, 10);
                end
            end
        end
        tx_busy = 1'b0;
        tx_done = 1'b0;
        if (tx_on) begin
            if (tx_fast) begin
                tx_busy = 1'b1; tx_done = 1'b1; tx_on = 1'b0;
            end else begin
                tx_busy = (tx_age >= tx_d) && (tx_age < tx_d + tx_l);
                tx_done = (tx_age == tx_d + tx_l);
                if (tx_done) tx_on = 1'b0;
                tx_age++;
            end
        end else if (!fair) begin
            p = $urandom_range(0, 15);
            tx_done = (p == 0);
            tx_busy = (p == 1);
        end
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) req[i] = 1'b0;
            else if (!req[i] && (fair || $urandom_range(0, 2) == 0)) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = fair ? 8'(8'h10 + i) : 8'($urandom);
            end
        end
        err_clr = fair ? 1'b0 : ($urandom_range(0, 31) == 0);
        reset   = fair ? 1'b0 : ($urandom_range(0, 299) == 0);
    endtask

    logic [7:0] seq[$];

    initial begin
        reset = 1'b1; req = '0; req_data = '0; tx_busy = 0; tx_done = 0; err_clr = 0;
        tick();

        //          rst   rq     rd             bz    dn    clr   ack    wr    wd     gid   bsy   err
        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'h4, 32'h0041_0000, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'h1, 32'h0000_00ee, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h41, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h41, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'h3, 32'h0000_2211, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'h2, 32'h0000_2211, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'h11, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'h2, 32'h0000_2211, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h22, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'h9, 32'h9900_0088, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 8'h88, 2'd0, 1'b1, 1'b0};

        for (int r = 0; r < 14; r++) begin
            reset = vecs[r].rst; req = vecs[r].rq; req_data = vecs[r].rd;
            tx_busy = vecs[r].bz; tx_done = vecs[r].dn; err_clr = vecs[r].clr;
            tick();
            check($sformatf("vec%0d", r), {15'b0, dut_vec()},
                  {15'b0, vecs[r].e_ack, vecs[r].e_wr, vecs[r].e_wd, vecs[r].e_gid,
                   vecs[r].e_bsy, vecs[r].e_err});
        end

        // Start timeout, then the next pending requester is served.
        reset = 1'b1; req = '0; tx_busy = 0; tx_done = 0; err_clr = 0;
        tick();
        reset = 1'b0; req = 4'b1010; req_data = 32'h7700_5500;
        tick();
        check("to_grant", {27'b0, ack, write}, {27'b0, 4'b0010, 1'b1});
        check("to_data", {24'b0, write_data}, 32'h55);
        req = 4'b1000;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 15) check("to_before", {30'b0, busy, start_err}, {30'b0, 2'b10});
        end
        tick();
        check("to_set", {30'b0, busy, start_err}, {30'b0, 2'b01});
        tick();
        check("to_next_ack", {28'b0, ack}, {28'b0, 4'b1000});
        check("to_next_data", {22'b0, grant_id, write_data}, {22'b0, 2'd3, 8'h77});
        req = 4'b0000;
        for (int i = 1; i <= 15; i++) tick();
        err_clr = 1'b1;
        tick();
        check("to_set_beats_clr", {31'b0, start_err}, 32'd1);
        tick();
        check("to_clr", {31'b0, start_err}, 32'd0);
        err_clr = 1'b0;

        // Fairness with all requesters continuously pending.
        reset = 1'b1; req = '0; tx_busy = 0; tx_done = 0; tx_on = 0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'(8'h10 + i);
        end
        for (int c = 0; c < 600 && seq.size() < 8; c++) begin
            tick();
            check("fair_model", {15'b0, dut_vec()},
                  {15'b0, m_ack, m_write, m_data, m_grant, m_inflight, m_err});
            if (write) seq.push_back(write_data);
            drive(1'b1);
        end
        check("fair_count", (seq.size() >= 8) ? 32'd8 : 32'(seq.size()), 32'd8);
        for (int k = 0; k < 8 && k < seq.size(); k++)
            check($sformatf("fair_seq%0d", k), {24'b0, seq[k]}, {24'b0, 8'(8'h10 + (k % 4))});

        // Randomized traffic against the reference model.
        reset = 1'b1; req = '0; tx_busy = 0; tx_done = 0; tx_on = 0; err_clr = 0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            check("rand_model", {15'b0, dut_vec()},
                  {15'b0, m_ack, m_write, m_data, m_grant, m_inflight, m_err});
            drive(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler sharing the single UART transmit path between `NUM_REQ` byte producers. Selects one pending requester, captures its byte, drives the one-cycle `write`/`write_data` strobe into the TX write latch, then holds off further issue until the transmitter reports the frame complete. It sits between the producers (keypad/ROM/echo sources) and the write-latch + UART TX pair.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 16: max cycles from `write` to `tx_busy` rising before a start fault.
- `clk_50M`  in  1  system clock, 50 MHz; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  bit i high: requester i has a byte pending; level, held until acked.
- `req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- `ack`  out  NUM_REQ  one-cycle pulse on bit i: byte of requester i captured.
- `write`  out  1  one-cycle strobe to TX write latch.
- `write_data`  out  8  captured byte; held stable from strobe until next grant.
- `tx_busy`  in  1  transmitter shifting a frame.
- `tx_done`  in  1  one-cycle pulse, stop bit finished.
- `grant_id`  out  clog2(NUM_REQ)  index of current/last granted requester.
- `busy`  out  1  high in any state except IDLE.
- `start_err`  out  1  sticky start-timeout fault.
- `err_clr`  in  1  clears `start_err`.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `req` bit high, pick first set bit searching from `rr_ptr` upward with wrap; capture `req_data` slice into hold register; go WAIT_BUSY; `rr_ptr` <= (winner+1) mod NUM_REQ. No request: stay, `rr_ptr` unchanged.
- WAIT_BUSY: start-timer counts from 0. `tx_done` high -> IDLE (fast transmitter; done wins over busy). Else `tx_busy` high -> WAIT_DONE. Else timer == START_TIMEOUT-1 -> set `start_err`, -> IDLE (byte dropped, not retried).
- WAIT_DONE: stay until `tx_done` -> IDLE. No timeout here.
- `req` is ignored outside IDLE; requesters keep `req` high until their `ack`, must drop or update `req_data` the cycle after `ack`.
- `start_err`: set has priority over `err_clr` in the same cycle; otherwise `err_clr` clears it.
- Timer width clog2(START_TIMEOUT)+1, saturates; cleared on entry to WAIT_BUSY.

## Timing
- Reset values: `ack`=0, `write`=0, `write_data`=0, `grant_id`=0, `busy`=0, `start_err`=0, `rr_ptr`=0, state IDLE, timer 0.
- Request sampled in IDLE at edge T -> `ack[i]`, `write`, new `write_data`, `grant_id`=i, `busy`=1 all visible T+1, for one cycle (ack/write).
- `tx_done` sampled at edge D -> IDLE at D+1; earliest next `write` at D+2. Back-to-back issue period = frame time + 2 cycles.
- Reset asserted mid-frame: all outputs to reset values next edge; in-flight byte abandoned, no further ack for it; late `tx_done` after reset is ignored in IDLE.
- `tx_done` in IDLE: ignored. `tx_busy` stuck high in IDLE: ignored.
- All requesters high continuously: grants strictly rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 grants.

## Structure
- Package `uart_ctrl_pkg`: state encoding constants (IDLE/WAIT_BUSY/WAIT_DONE), byte width 8, default NUM_REQ and START_TIMEOUT.
- Sub-module `rr_pick`: combinational rotating-priority finder (inputs `req`, `rr_ptr`; outputs `valid`, `idx`). FSM, hold register, timer and error flag stay in top.

## Test plan
- Single request: `req`=4'b0100, data 8'h41; transmitter model asserts busy 3 cycles after write, done 20 cycles later -> one `ack[2]`, one `write` with 8'h41, `grant_id`=2, next grant ≥2 cycles after done.
- Fairness: all four `req` held high with data 8'h10..8'h13, each re-raised after ack -> write sequence 10,11,12,13,10,... ; `rr_ptr` wraps.
- Start timeout: `tx_busy` never rises -> `start_err`=1 exactly START_TIMEOUT cycles after entering WAIT_BUSY, FSM IDLE, next pending request served; `err_clr` same cycle as a second timeout -> `start_err` stays 1.
- Fast transmitter: `tx_done` and `tx_busy` both high in first WAIT_BUSY cycle -> returns to IDLE, no hang in WAIT_DONE.
- Reset mid-frame: `reset` during WAIT_DONE, then spurious `tx_done` -> all outputs 0, no `write`/`ack` generated, `rr_ptr`=0 so requester 0 wins next.
